nn_result_collector: RTL
========================

// Module: nn_result_collector
// PURPOSE
//  Receiving end of the network's result stream. Captures each 8-bit class result from the
//  NN controller/datapath on every batch_done pulse, compares it against the expected label
//  from an external combinational label ROM, and keeps sample/correct/mismatch counts.
//  Sits beside the NeuralNetwork top; provides per-run accuracy for the 750-sample test set.
// PARAMETERS
//  DATA_W      8    width of result and label
//  NUM_SAMPLES 750  samples per run; run closes after this many results
//  CNT_W       10   width of sample/correct counters and label_addr (>= clog2(NUM_SAMPLES+1))
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       synchronous, active-high reset
//  start        in   1       1-cycle pulse: clear counters, begin run
//  res_in       in   DATA_W  network result (test_out), valid when res_valid=1
//  res_valid    in   1       result strobe (batch_done), one cycle per sample
//  nn_done      in   1       network finished whole run (done)
//  label_in     in   DATA_W  expected label from ROM at label_addr (combinational, same cycle)
//  label_addr   out  CNT_W   ROM index = sample_cnt
//  sample_cnt   out  CNT_W   results accepted this run
//  correct_cnt  out  CNT_W   results equal to label
//  last_result  out  DATA_W  most recently accepted res_in
//  mismatch     out  1       1-cycle pulse, cycle after a wrong result
//  busy         out  1       high in RUN
//  acc_done     out  1       high in DONE, held until next start
//  short_run    out  1       DONE reached by nn_done before NUM_SAMPLES results
//  overrun      out  1       sticky: res_valid seen outside RUN
// BEHAVIOUR
//  - Reset: state IDLE. All counters, last_result, mismatch, busy, acc_done, short_run and
//    overrun are 0.
//  - FSM: IDLE -start-> RUN; RUN -(NUM_SAMPLES-th accepted result | nn_done)-> DONE;
//    DONE -start-> RUN. start in RUN restarts the run: counters clear, state stays RUN.
//  - Entering RUN from start: sample_cnt, correct_cnt, last_result, short_run, overrun := 0.
//  - Accept in RUN when res_valid=1: compare res_in with label_in (full DATA_W equality).
//    Next edge: sample_cnt+1, correct_cnt+1 if equal, last_result := res_in,
//    mismatch := (res_in != label_in). Counts are visible 1 cycle after the strobe.
//  - label_addr = sample_cnt (combinational), so the label for sample k is addressed while
//    waiting for strobe k.
//  - Closing on count: when an accepted result brings sample_cnt to NUM_SAMPLES, go to DONE
//    on the same edge, with short_run=0.
//  - nn_done in RUN: go to DONE. short_run := 1 if the final sample_cnt < NUM_SAMPLES.
//  - res_valid and nn_done in the same cycle: the sample is counted first, then DONE.
//    short_run is evaluated using the incremented count.
//  - start and res_valid in the same cycle: start wins; the sample is discarded.
//  - res_valid in IDLE/DONE: ignored, counters hold, overrun := 1 (sticky until start/rst).
//  - Counters never wrap: at most NUM_SAMPLES accepts per run.
//  - mismatch is 0 in every cycle not directly following a wrong accept.
//  - busy = (state==RUN); acc_done = (state==DONE); both registered from the state.
//  - rst mid-run: immediate return to the IDLE/reset values. The partial run is lost.
// TESTING
//  1. rst, start, 750 strobes with res_in=label_in -> sample_cnt=750, correct_cnt=750,
//     acc_done=1, short_run=0, mismatch never high.
//  2. Strobe 5 with res_in=label^1, rest matching -> mismatch pulses 1 cycle after strobe 5
//     only, final correct_cnt=749.
//  3. 100 strobes then nn_done -> DONE, sample_cnt=100, short_run=1. Strobe 100 coincident
//     with nn_done -> sample_cnt=100.
//  4. res_valid in IDLE and after DONE -> overrun=1, counters unchanged. Next start clears
//     overrun.
//  5. start after 40 strobes (in RUN), also coincident with a strobe -> counters read 0 the
//     next cycle, busy stays 1, and the coincident sample is not counted.
//  6. rst asserted at sample 300 -> next cycle: all outputs 0, state IDLE. start then runs
//     normally from label_addr=0.

Source files
------------

// File: rtl/nn_result_collector.sv
// Result collector for the network's output stream: scores each result against the label ROM
// and keeps per-run sample/correct counts, closing the run on a full count or on nn_done.
module nn_result_collector #(
  parameter int DATA_W      = 8,
  parameter int NUM_SAMPLES = 750,
  parameter int CNT_W       = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] res_in,
  input  logic              res_valid,
  input  logic              nn_done,
  input  logic [DATA_W-1:0] label_in,
  output logic [CNT_W-1:0]  label_addr,
  output logic [CNT_W-1:0]  sample_cnt,
  output logic [CNT_W-1:0]  correct_cnt,
  output logic [DATA_W-1:0] last_result,
  output logic              mismatch,
  output logic              busy,
  output logic              acc_done,
  output logic              short_run,
  output logic              overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_SAMPLES);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t           state;
  logic             hit;
  logic [CNT_W-1:0] next_cnt;
  logic [CNT_W-1:0] final_cnt;

  assign hit        = (res_in == label_in);
  assign next_cnt   = sample_cnt + ONE;
  // Count that the run closes with: a strobe coincident with nn_done is counted first.
  assign final_cnt  = res_valid ? next_cnt : sample_cnt;
  assign label_addr = sample_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sample_cnt  <= '0;
      correct_cnt <= '0;
      last_result <= '0;
      mismatch    <= 1'b0;
      busy        <= 1'b0;
      acc_done    <= 1'b0;
      short_run   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      mismatch <= 1'b0;
      if (start) begin
        // start outranks any coincident strobe, which is dropped rather than counted.
        state       <= RUN;
        busy        <= 1'b1;
        acc_done    <= 1'b0;
        sample_cnt  <= '0;
        correct_cnt <= '0;
        last_result <= '0;
        short_run   <= 1'b0;
        overrun     <= 1'b0;
      end else begin
        case (state)
          RUN: begin
            if (res_valid) begin
              sample_cnt  <= next_cnt;
              last_result <= res_in;
              mismatch    <= ~hit;
              if (hit) begin
                correct_cnt <= correct_cnt + ONE;
              end
            end
            if ((res_valid && (next_cnt == FULL_CNT)) || nn_done) begin
              state     <= DONE;
              busy      <= 1'b0;
              acc_done  <= 1'b1;
              short_run <= (final_cnt < FULL_CNT);
            end
          end
          default: begin
            if (res_valid) begin
              overrun <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule
